// File: rtl/imem_fetch_pkg.sv
// ============================================================================
// Module      : imem_fetch_pkg
// Description : Shared types, constants and image word selector for imem_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_fetch_pkg;

    localparam int WORDS = 16;
    localparam int IW    = 16;
    localparam int PC_W  = $clog2(WORDS);

    localparam logic [3:0] HALT_OP = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    function automatic logic [IW-1:0] word_sel(input logic [WORDS*IW-1:0] img,
                                               input logic [PC_W-1:0]     idx);
        return img[int'(idx)*IW +: IW];
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_fetch_outreg.sv
// ============================================================================
// Module      : imem_fetch_outreg
// Description : Output holding register toward decode (valid/ready, load, flush).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch_outreg
    import imem_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic            instr_ready,
    input  logic [IW-1:0]   load_instr,
    input  logic [PC_W-1:0] load_pc,
    output logic            can_load,
    output logic            instr_valid,
    output logic [IW-1:0]   instr,
    output logic [PC_W-1:0] instr_pc
);

    logic            valid_q, valid_d;
    logic [IW-1:0]   instr_q, instr_d;
    logic [PC_W-1:0] pc_q, pc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    // Flush only drops valid; the word itself is held until the next load.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end
    end

    assign can_load    = !valid_q || instr_ready;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = pc_q;

endmodule

`default_nettype wire

// File: rtl/imem_fetch.sv
// ============================================================================
// Module      : imem_fetch
// Description : Program-image fetch sequencer with redirect and halt handling.
//               Optional handshake counter enabled by macro FETCH_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch
    import imem_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORDS*IW-1:0]   prgm_words,
    input  logic                  start,
    input  logic                  redirect_valid,
    input  logic [PC_W-1:0]       redirect_addr,
    input  logic                  instr_ready,
`ifdef FETCH_PERF_EN
    output logic [7:0]            fetch_count,
`endif
    output logic                  instr_valid,
    output logic [IW-1:0]         instr,
    output logic [PC_W-1:0]       instr_pc,
    output logic                  halted
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            halted_q, halted_d;
    logic            load, flush, can_load;
    logic [IW-1:0]   cur_word;
    logic            cur_is_halt, handshake, start_ok;

    assign cur_word    = word_sel(prgm_words, pc_q);
    assign cur_is_halt = (cur_word[IW-1:IW-4] == HALT_OP);
    assign handshake   = instr_valid && instr_ready;
    assign start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_HALT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALT: if (start) state_d = ST_RUN;
            ST_RUN:   if (!redirect_valid && can_load && cur_is_halt) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (redirect_valid)  state_d = ST_RUN;
                else if (handshake)  state_d = ST_HALT;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Redirect outranks both fetch and halt completion.
    always_comb begin
        load     = 1'b0;
        flush    = 1'b0;
        pc_d     = pc_q;
        halted_d = halted_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_d     = '0;
                    halted_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = redirect_addr;
                end else if (can_load) begin
                    load = 1'b1;
                    pc_d = pc_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = redirect_addr;
                end else if (handshake) begin
                    flush    = 1'b1;
                    halted_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    imem_fetch_outreg u_outreg (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .flush       (flush),
        .instr_ready (instr_ready),
        .load_instr  (cur_word),
        .load_pc     (pc_q),
        .can_load    (can_load),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    assign halted = halted_q;

`ifdef FETCH_PERF_EN
    logic [7:0] fetch_count_q, fetch_count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fetch_count_q <= '0;
        else     fetch_count_q <= fetch_count_d;
    end

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (start_ok)
            fetch_count_d = '0;
        else if (handshake && (fetch_count_q != 8'hFF))
            fetch_count_d = fetch_count_q + 8'd1;
    end

    assign fetch_count = fetch_count_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch.sv
// ============================================================================
// Module      : tb_imem_fetch
// Description : Self-checking bench for imem_fetch (vector table, directed
//               sequences, randomized run against a behavioural model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_fetch;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] prgm_words;
    logic         start, redirect_valid, instr_ready;
    logic [3:0]   redirect_addr;
    logic         instr_valid, halted;
    logic [15:0]  instr;
    logic [3:0]   instr_pc;
`ifdef FETCH_PERF_EN
    logic [7:0]   fetch_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    imem_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .prgm_words     (prgm_words),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr_ready    (instr_ready),
`ifdef FETCH_PERF_EN
        .fetch_count    (fetch_count),
`endif
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          start;
        bit          ready;
        bit          e_valid;
        logic [15:0] e_instr;
        logic [3:0]  e_pc;
        bit          e_halted;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit s, bit r, bit v, logic [15:0] i, logic [3:0] p, bit h);
        vec_t x;
        x.start = s; x.ready = r; x.e_valid = v; x.e_instr = i; x.e_pc = p; x.e_halted = h;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string nm, input bit v, input logic [15:0] i,
                           input logic [3:0] p, input bit h);
        chk({nm, ".valid"},  {31'd0, instr_valid}, {31'd0, v});
        chk({nm, ".halted"}, {31'd0, halted},      {31'd0, h});
        chk({nm, ".instr"},  {16'd0, instr},       {16'd0, i});
        chk({nm, ".pc"},     {28'd0, instr_pc},    {28'd0, p});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input bit r, input bit rv, input logic [3:0] ra);
        start = s; instr_ready = r; redirect_valid = rv; redirect_addr = ra;
    endtask

    task automatic wait_pc(input logic [3:0] p);
        int n = 0;
        drive(0, 1, 0, 0);
        while (!(instr_valid && instr_pc == p) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_pc: pc %0h never valid, last pc %0h", p, instr_pc);
        end
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Behavioural reference: mode 0=idle 1=fetching 2=halt word pending 3=stopped
    int          m_mode, m_next;
    bit          m_valid, m_halted;
    logic [15:0] m_instr;
    logic [3:0]  m_pc;
    int          m_cnt;

    task automatic model_reset();
        m_mode = 0; m_next = 0; m_valid = 0; m_halted = 0;
        m_instr = 16'h0; m_pc = 4'h0; m_cnt = 0;
    endtask

    task automatic model_step(input bit s, input bit r, input bit rv, input logic [3:0] ra);
        bit          accepted;
        logic [15:0] w;
        accepted = m_valid && r;
        if (accepted) m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
        if (m_mode == 0 || m_mode == 3) begin
            if (s) begin
                m_mode = 1; m_next = 0; m_halted = 0; m_cnt = 0;
            end
        end else if (rv) begin
            m_mode = 1; m_next = int'(ra); m_valid = 0;
        end else if (m_mode == 1) begin
            if (!m_valid || r) begin
                w = prgm_words[16*m_next +: 16];
                m_instr = w; m_pc = 4'(m_next); m_valid = 1;
                m_next = (m_next + 1) % 16;
                if (w[15:12] == 4'hF) m_mode = 2;
            end
        end else if (accepted) begin
            m_valid = 0; m_halted = 1; m_mode = 3;
        end
    endtask

    initial begin
        logic [15:0] w;
        bit s, r, rv;
        logic [3:0] ra;

        rst = 1'b1;
        drive(0, 0, 0, 0);
        prgm_words = '0;
        prgm_words[15:0]  = 16'h0000;
        prgm_words[31:16] = 16'h1400;
        prgm_words[47:32] = 16'h3802;
        prgm_words[63:48] = 16'hF000;
        #1;
        chk_out("reset", 0, 16'h0, 4'h0, 0);
`ifdef FETCH_PERF_EN
        chk("reset.count", {24'd0, fetch_count}, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Straight run to halt, then restart under back-pressure
        vt.push_back(mk(1, 1, 0, 16'h0000, 4'h0, 0));
        vt.push_back(mk(0, 1, 1, 16'h0000, 4'h0, 0));
        vt.push_back(mk(0, 1, 1, 16'h1400, 4'h1, 0));
        vt.push_back(mk(0, 1, 1, 16'h3802, 4'h2, 0));
        vt.push_back(mk(0, 1, 1, 16'hF000, 4'h3, 0));
        vt.push_back(mk(0, 1, 0, 16'hF000, 4'h3, 1));
        vt.push_back(mk(0, 1, 0, 16'hF000, 4'h3, 1));
        vt.push_back(mk(1, 0, 0, 16'hF000, 4'h3, 0));
        vt.push_back(mk(0, 0, 1, 16'h0000, 4'h0, 0));
        vt.push_back(mk(0, 0, 1, 16'h0000, 4'h0, 0));
        vt.push_back(mk(0, 0, 1, 16'h0000, 4'h0, 0));
        vt.push_back(mk(0, 0, 1, 16'h0000, 4'h0, 0));
        vt.push_back(mk(0, 1, 1, 16'h1400, 4'h1, 0));
        vt.push_back(mk(0, 0, 1, 16'h1400, 4'h1, 0));
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].start, vt[i].ready, 0, 0);
            step();
            chk_out($sformatf("vec%0d", i), vt[i].e_valid, vt[i].e_instr, vt[i].e_pc, vt[i].e_halted);
`ifdef FETCH_PERF_EN
            if (i == 6) chk("count_after_halt", {24'd0, fetch_count}, 32'd4);
            if (i == 7) chk("count_cleared_by_start", {24'd0, fetch_count}, 32'd0);
`endif
        end

        // Halt word pending in DRAIN is discarded by a redirect
        drive(0, 1, 0, 0);
        step();
        chk_out("drain.w2", 1, 16'h3802, 4'h2, 0);
        step();
        chk_out("drain.w3", 1, 16'hF000, 4'h3, 0);
        drive(0, 0, 1, 4'h1);
        step();
        chk_out("drain.flush", 0, 16'hF000, 4'h3, 0);
        drive(0, 1, 0, 0);
        step();
        chk_out("drain.target", 1, 16'h1400, 4'h1, 0);
        step();
        chk_out("midrst.pc2", 1, 16'h3802, 4'h2, 0);

        // Asynchronous reset mid-run
        #2 rst = 1'b1;
        #1;
        chk_out("async_rst", 0, 16'h0, 4'h0, 0);
`ifdef FETCH_PERF_EN
        chk("async_rst.count", {24'd0, fetch_count}, 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1, 1, 0, 0);
        step();
        drive(0, 1, 0, 0);
        step();
        chk_out("restart", 1, 16'h0000, 4'h0, 0);

        // Redirect while pc 5 valid, then PC wrap
        sync_reset();
        for (int i = 0; i < 16; i++) prgm_words[16*i +: 16] = 16'h2000 | 16'(i);
        prgm_words[95:80] = 16'hB002;
        drive(1, 1, 0, 0);
        step();
        wait_pc(4'h5);
        drive(0, 1, 1, 4'h2);
        step();
        chk("redir.valid_drop", {31'd0, instr_valid}, 32'd0);
        drive(0, 1, 0, 0);
        step();
        chk_out("redir.t0", 1, 16'h2002, 4'h2, 0);
        step();
        chk_out("redir.t1", 1, 16'h2003, 4'h3, 0);
        step();
        chk_out("redir.t2", 1, 16'h2004, 4'h4, 0);
        step();
        chk_out("redir.t3", 1, 16'hB002, 4'h5, 0);
        step();
        chk_out("redir.t4", 1, 16'h2006, 4'h6, 0);
        wait_pc(4'hE);
        step();
        chk_out("wrap.15", 1, 16'h200F, 4'hF, 0);
        step();
        chk_out("wrap.0", 1, 16'h2000, 4'h0, 0);
        step();
        chk_out("wrap.1", 1, 16'h2001, 4'h1, 0);

        // Randomized run against the reference model
        for (int i = 0; i < 16; i++) begin
            w = 16'($urandom);
            w[15:12] = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            prgm_words[16*i +: 16] = w;
        end
        drive(0, 0, 0, 0);
        sync_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            s  = ($urandom_range(0, 19) == 0);
            r  = ($urandom_range(0, 9) < 7);
            rv = ($urandom_range(0, 7) == 0);
            ra = 4'($urandom_range(0, 15));
            model_step(s, r, rv, ra);
            drive(s, r, rv, ra);
            step();
            chk_out($sformatf("rand%0d", c), m_valid, m_instr, m_pc, m_halted);
`ifdef FETCH_PERF_EN
            chk($sformatf("rand%0d.count", c), {24'd0, fetch_count}, 32'(m_cnt));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
